fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction fetch unit.
package fetch_pkg;
    localparam int IMEM_WORDS  = 32;
    localparam int IMEM_AWIDTH = $clog2(IMEM_WORDS);

    typedef enum logic [1:0] {IDLE, RUN, FULL} fetch_state_t;

    function automatic logic [IMEM_AWIDTH-1:0] pc_inc(input logic [IMEM_AWIDTH-1:0] pc);
        return pc + IMEM_AWIDTH'(1);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with pointer/count registers and a
// synchronous flush that overrides push and pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [DW-1:0]                head_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count_nxt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observable through a non-zero count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count_nxt = count_d;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads the 32-word instruction segment into a prefetch
// buffer. Optional push/stall counters are built when FETCH_STATS_EN is defined.
//
// state | meaning
// IDLE  | fetch_en low, no new fetches
// RUN   | fetching, buffer has room
// FULL  | fetching enabled but buffer full
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int INSTRUCTIONWIDTH = 24,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_en,
    output logic [WIDTH-1:0]            imem_addr,
    input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
    input  logic                        redirect,
    input  logic [WIDTH-1:0]            redirect_pc,
    output logic [INSTRUCTIONWIDTH-1:0] instr,
    output logic [WIDTH-1:0]            instr_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [WIDTH-1:0]            fetch_count,
    output logic [WIDTH-1:0]            stall_count
`endif
);
    localparam int EW = INSTRUCTIONWIDTH + IMEM_AWIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t            state_q, state_d;
    logic [IMEM_AWIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic                    push, pop, fifo_empty, fifo_full, full_nxt;
    logic [EW-1:0]           head;
    logic [CW-1:0]           count_nxt;
    logic [WIDTH-IMEM_AWIDTH-1:0] unused_redirect_hi;

    assign unused_redirect_hi = redirect_pc[WIDTH-1:IMEM_AWIDTH];

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready && !redirect;
    // A full buffer still accepts a fetch when the head leaves in the same cycle.
    assign push        = fetch_en && !redirect && (!fifo_full || pop);

    fetch_fifo #(.DEPTH(DEPTH), .DW(EW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data ({imem_rdata, fetch_pc_q}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count_nxt (count_nxt)
    );

    assign full_nxt = (count_nxt == CW'(DEPTH));

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc[IMEM_AWIDTH-1:0];
        end else if (push) begin
            fetch_pc_d = pc_inc(fetch_pc_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en) state_d = full_nxt ? FULL : RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
                     else if (full_nxt) state_d = FULL;
            FULL:    if (!fetch_en) state_d = IDLE;
                     else if (!full_nxt) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign imem_addr = WIDTH'(fetch_pc_q);
    assign instr     = instr_valid ? head[EW-1:IMEM_AWIDTH] : '0;
    assign instr_pc  = instr_valid ? WIDTH'(head[IMEM_AWIDTH-1:0]) : '0;

`ifdef FETCH_STATS_EN
    logic [WIDTH-1:0] fetch_count_q, fetch_count_d, stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (push && (fetch_count_q != '1)) fetch_count_d = fetch_count_q + 1'b1;
        if ((state_q == FULL) && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int WIDTH = 16;
    localparam int IW    = 24;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_en = 1'b0;
    logic [WIDTH-1:0] imem_addr;
    logic [IW-1:0]   imem_rdata;
    logic            redirect = 1'b0;
    logic [WIDTH-1:0] redirect_pc = '0;
    logic [IW-1:0]   instr;
    logic [WIDTH-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
`ifdef FETCH_STATS_EN
    logic [WIDTH-1:0] fetch_count, stall_count;
`endif

    fetch_unit #(.WIDTH(WIDTH), .INSTRUCTIONWIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    logic [IW-1:0] imem [32];
    assign imem_rdata = imem[imem_addr[4:0]];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: buffered PCs in order, next fetch PC, pushes since reset.
    int q[$];
    int mpc = 0;
    int mpushes = 0;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        exp_valid;
        int          exp_pc;
        int          exp_addr;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, instr_valid}, 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_pc", 32'(instr_pc), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        mpc = 0;
        mpushes = 0;
    endtask

    task automatic mcheck(input string tag);
        chk({tag, "_valid"}, {31'b0, instr_valid}, (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) begin
            chk({tag, "_pc"}, 32'(instr_pc), q[0]);
            chk({tag, "_instr"}, 32'(instr), 32'(imem[q[0]]));
        end
        chk({tag, "_addr"}, 32'(imem_addr), mpc);
    endtask

    task automatic mstep();
        bit do_pop, do_push;
        do_pop  = (q.size() > 0) && instr_ready && !redirect;
        do_push = fetch_en && !redirect && ((q.size() < DEPTH) || do_pop);
        if (redirect) begin
            q.delete();
            mpc = int'(redirect_pc) % 32;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(mpc);
                mpc = (mpc + 1) % 32;
                mpushes++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) imem[i] = IW'($urandom);

        // en, rdy, redir, rpc, exp_valid, exp_pc, exp_addr (outputs after the edge)
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 0,  1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1,  2};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2,  3};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0,  3};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3,  4};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3,  5};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'h001E, 1'b0, 0,  30};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 30, 31};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 31, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 0,  1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1,  2};

        do_reset();
        chk("idle_after_rst", {30'b0, dut.state_q}, {30'b0, IDLE});
        for (int i = 0; i < 11; i++) begin
            fetch_en    = tbl[i].en;
            instr_ready = tbl[i].rdy;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), tbl[i].exp_addr);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), 32'(instr_pc), tbl[i].exp_pc);
                chk($sformatf("tbl%0d_instr", i), 32'(instr), 32'(imem[tbl[i].exp_pc]));
            end
        end

        // Backpressure: ten stalled cycles fill the buffer with PCs 0..3.
        do_reset();
        fetch_en = 1'b1;
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mstep();
            mcheck("bp");
            chk("bp_head_held", 32'(instr_pc), 0);
        end
        chk("bp_addr", 32'(imem_addr), 4);
        chk("bp_state", {30'b0, dut.state_q}, {30'b0, FULL});
`ifdef FETCH_STATS_EN
        chk("bp_fetch_count", 32'(fetch_count), 4);
        // FULL is entered after the 4th edge and held through the remaining 6 cycles.
        chk("bp_stall_count", 32'(stall_count), 6);
`endif

        // Redirect while full and popping: flush, next PC comes from redirect_pc[4:0].
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0025;
        mstep();
        chk("rd_valid", {31'b0, instr_valid}, 0);
        chk("rd_addr", 32'(imem_addr), 5);
        redirect = 1'b0;
        mstep();
        chk("rd_pc0", 32'(instr_pc), 5);
        mcheck("rd0");
        mstep();
        chk("rd_pc1", 32'(instr_pc), 6);
        mcheck("rd1");

        // Mid-run reset at occupancy 3.
        do_reset();
        fetch_en = 1'b1;
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) mstep();
        mcheck("pre_rst");
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'b0, instr_valid}, 0);
        chk("mrst_instr", 32'(instr), 0);
        chk("mrst_pc", 32'(instr_pc), 0);
        chk("mrst_addr", 32'(imem_addr), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        mpc = 0;
        mpushes = 0;
        instr_ready = 1'b1;
        mstep();
        chk("mrst_first_valid", {31'b0, instr_valid}, 1);
        chk("mrst_first_pc", 32'(instr_pc), 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            fetch_en    = ($urandom_range(0, 9) < 8);
            instr_ready = ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = WIDTH'($urandom_range(0, 65535));
            mcheck("rnd_pre");
            mstep();
        end
        redirect = 1'b0;
        mcheck("rnd_end");
`ifdef FETCH_STATS_EN
        chk("rnd_fetch_count", 32'(fetch_count), mpushes);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
